l2_arbiter: RTL and testbench
=============================

// Module: l2_arbiter
// PURPOSE
//  Two-port Wishbone arbiter that shares the single L2 cache slave port
//  between the L1 I-cache (port I) and the L1 D-cache (port D).
//  - Grants one whole line transaction (STB..ACK) at a time.
//  - Resolves simultaneous requests round-robin.
//  - Keeps saturating per-port grant counters for performance analysis.
//  Sits between the two L1 wishbone masters and the L2 wishbone slave.
// PARAMETERS
//  ADDR_W  12   line address width (byte address [15:4])
//  DATA_W  128  line data width
//  SEL_W   16   byte-select width
//  CNT_W   16   width of each grant counter
// PORTS
//  clk           in   1       system clock; all state on rising edge
//  rst_n         in   1       asynchronous, active-low reset
//  i_cyc,i_stb   in   1       port I cycle/strobe
//  i_we          in   1       port I write enable (I-cache: always 0)
//  i_adr         in   ADDR_W  port I line address
//  i_sel         in   SEL_W   port I byte selects
//  i_dat_m       in   DATA_W  port I write data
//  i_dat_s       out  DATA_W  port I read data
//  i_ack         out  1       port I acknowledge
//  d_cyc,d_stb,d_we,d_adr,d_sel,d_dat_m,d_dat_s,d_ack   same set for port D
//  l2_cyc,l2_stb out  1       to L2 slave
//  l2_we         out  1       to L2 slave
//  l2_adr        out  ADDR_W  to L2 slave
//  l2_sel        out  SEL_W   to L2 slave
//  l2_dat_m      out  DATA_W  to L2 slave
//  l2_dat_s      in   DATA_W  from L2 slave
//  l2_ack        in   1       from L2 slave
//  gnt_cnt_i     out  CNT_W   completed port I transactions, saturating
//  gnt_cnt_d     out  CNT_W   completed port D transactions, saturating
// BEHAVIOUR
//  Request and pointer
//  - Port X requests when x_cyc & x_stb.
//  - FSM states: IDLE, OWN_I, OWN_D. Round-robin pointer rr: 0 = I preferred.
//  Reset (rst_n low, asynchronous)
//  - state=IDLE, rr=0, counters=0.
//  - All l2_* outputs 0; i_ack=d_ack=0.
//  Arbitration
//  - IDLE: one requester -> grant it. Both -> grant the preferred port.
//    Neither -> stay in IDLE.
//  - The grant is registered. A request first seen in IDLE at edge N drives
//    l2_cyc/stb from cycle N+1 (1-cycle arbitration latency).
//  - OWN_X: l2_{cyc,stb,we,adr,sel,dat_m} = X's signals (combinational mux).
//    Outside OWN_X these outputs are 0.
//  Acknowledge and data return
//  - x_ack = l2_ack & (state==OWN_X); the other port's ack is held 0.
//  - i_dat_s = d_dat_s = l2_dat_s (broadcast); only the acked port samples it.
//  Completion and abort
//  - OWN_X with l2_ack: go to IDLE, rr points at the other port,
//    gnt_cnt_x += 1 (holds at all-ones).
//  - The mandatory IDLE cycle lets the master drop STB before re-arbitration.
//    Back-to-back requests from one master therefore cost 1 bubble.
//  - OWN_X with x_cyc low (abort): go to IDLE; rr and counters unchanged.
//    l2_cyc drops in the same cycle.
//  Boundary conditions
//  - Both ports hold requests continuously -> grants alternate I,D,I,D.
//    A port never waits more than one foreign transaction.
//  - Requester changes adr/we mid-grant: passed through unchanged. Masters
//    must hold request signals stable until ack (Wishbone rule).
//  - l2_ack in IDLE is ignored: no ack to either port, no state change.
//  - Reset mid-transaction: immediate IDLE. L2 sees CYC fall (abort).
// STRUCTURE
//  - Shared package lc3b_types: typedef lc3b_line_addr (logic[11:0]),
//    lc3b_line (logic[127:0]), enum arb_state_t {IDLE,OWN_I,OWN_D}.
//  - Sub-module arb_gnt_counter (saturating CNT_W counter with
//    inc/clear/async rst_n), instantiated twice.
//  - FSM, round-robin pointer and output mux stay in this module.
// TESTING
//  1. Single read: I requests adr=12'h0A3; L2 acks 3 cycles later with
//     data 128'hDEAD.. -> l2_adr=0A3 from cycle+1; i_ack 1 cycle with data;
//     d_ack=0; gnt_cnt_i=1.
//  2. Simultaneous: I and D both request after reset -> I granted first,
//     then D after 1 IDLE bubble; next tie -> I again (rr rotated).
//  3. Continuous contention for 8 transactions -> strict I,D alternation;
//     gnt_cnt_i=gnt_cnt_d=4.
//  4. D write (we=1, dat_m=128'h1234..) while I idle -> l2_we=1 and
//     l2_dat_m matches; I sees no ack.
//  5. Abort: grant D, drop d_cyc before ack -> IDLE next cycle, l2_cyc=0,
//     counter unchanged. Stray l2_ack in IDLE is ignored.
//  6. Assert rst_n=0 mid-grant -> l2_cyc=0 immediately; counters 0.
//     Counter forced to 16'hFFFF stays at FFFF after a further grant.

Source files
------------

// File: rtl/l2_arbiter_pkg.sv
// lc3b_types: shared line types, default widths and arbiter state encoding.
//   LINE_ADDR_W/LINE_W/LINE_SEL_W/GNT_CNT_W : default widths for the L2 arbiter
//   lc3b_line_addr, lc3b_line               : line address / line data types
//   arb_state_t                             : IDLE, OWN_I, OWN_D
package lc3b_types;
    localparam int LINE_ADDR_W = 12;
    localparam int LINE_W      = 128;
    localparam int LINE_SEL_W  = 16;
    localparam int GNT_CNT_W   = 16;
    typedef logic [LINE_ADDR_W-1:0] lc3b_line_addr;
    typedef logic [LINE_W-1:0] lc3b_line;
    typedef enum logic [1:0] {IDLE, OWN_I, OWN_D} arb_state_t;
endpackage

// File: rtl/l2_arbiter_gnt_counter.sv
// arb_gnt_counter: saturating event counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_inc      : count one event (held once all-ones)
//   i_clr      : synchronous clear
//   o_cnt      : current count
module arb_gnt_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_cnt
);
    logic [CNT_W-1:0] r_cnt;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_cnt <= '0;
        else if (i_clr) r_cnt <= '0;
        else if (i_inc && r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
    assign o_cnt = r_cnt;
endmodule

// File: rtl/l2_arbiter.sv
// l2_arbiter: round-robin Wishbone arbiter sharing the L2 slave between I and D L1 caches.
//   clk, rst_n                        : clock, asynchronous active-low reset
//   i_{cyc,stb,we,adr,sel,dat_m}      : port I master request
//   i_dat_s, i_ack                    : port I read data / acknowledge
//   d_*                               : same set for port D
//   l2_{cyc,stb,we,adr,sel,dat_m}     : muxed request to the L2 slave
//   l2_dat_s, l2_ack                  : L2 slave response
//   gnt_cnt_i, gnt_cnt_d              : saturating completed-transaction counts
module l2_arbiter
    import lc3b_types::*;
#(
    parameter int ADDR_W = LINE_ADDR_W,
    parameter int DATA_W = LINE_W,
    parameter int SEL_W  = LINE_SEL_W,
    parameter int CNT_W  = GNT_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_cyc,
    input  logic              i_stb,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_adr,
    input  logic [SEL_W-1:0]  i_sel,
    input  logic [DATA_W-1:0] i_dat_m,
    output logic [DATA_W-1:0] i_dat_s,
    output logic              i_ack,
    input  logic              d_cyc,
    input  logic              d_stb,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_adr,
    input  logic [SEL_W-1:0]  d_sel,
    input  logic [DATA_W-1:0] d_dat_m,
    output logic [DATA_W-1:0] d_dat_s,
    output logic              d_ack,
    output logic              l2_cyc,
    output logic              l2_stb,
    output logic              l2_we,
    output logic [ADDR_W-1:0] l2_adr,
    output logic [SEL_W-1:0]  l2_sel,
    output logic [DATA_W-1:0] l2_dat_m,
    input  logic [DATA_W-1:0] l2_dat_s,
    input  logic              l2_ack,
    output logic [CNT_W-1:0]  gnt_cnt_i,
    output logic [CNT_W-1:0]  gnt_cnt_d
);
    arb_state_t r_state, w_next;
    logic r_rr, w_rr_next, w_inc_i, w_inc_d;
    logic w_req_i, w_req_d, w_own_i, w_own_d;

    assign w_req_i = i_cyc & i_stb;
    assign w_req_d = d_cyc & d_stb;
    assign w_own_i = r_state == OWN_I;
    assign w_own_d = r_state == OWN_D;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_state <= IDLE;
            r_rr    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_rr    <= w_rr_next;
        end

    // rr=0 prefers I; a completed grant points rr at the other port, an abort leaves it alone
    always_comb begin
        w_next    = r_state;
        w_rr_next = r_rr;
        w_inc_i   = 1'b0;
        w_inc_d   = 1'b0;
        case (r_state)
            IDLE:  w_next = (w_req_i && (!w_req_d || !r_rr)) ? OWN_I : w_req_d ? OWN_D : IDLE;
            OWN_I: begin
                w_next    = (l2_ack || !i_cyc) ? IDLE : OWN_I;
                w_rr_next = l2_ack ? 1'b1 : r_rr;
                w_inc_i   = l2_ack;
            end
            OWN_D: begin
                w_next    = (l2_ack || !d_cyc) ? IDLE : OWN_D;
                w_rr_next = l2_ack ? 1'b0 : r_rr;
                w_inc_d   = l2_ack;
            end
            default: w_next = IDLE;
        endcase
    end

    assign l2_cyc   = (w_own_i & i_cyc) | (w_own_d & d_cyc);
    assign l2_stb   = (w_own_i & i_stb) | (w_own_d & d_stb);
    assign l2_we    = (w_own_i & i_we) | (w_own_d & d_we);
    assign l2_adr   = w_own_i ? i_adr : w_own_d ? d_adr : '0;
    assign l2_sel   = w_own_i ? i_sel : w_own_d ? d_sel : '0;
    assign l2_dat_m = w_own_i ? i_dat_m : w_own_d ? d_dat_m : '0;
    assign i_ack    = l2_ack & w_own_i;
    assign d_ack    = l2_ack & w_own_d;
    assign i_dat_s  = l2_dat_s;
    assign d_dat_s  = l2_dat_s;

    arb_gnt_counter #(.CNT_W(CNT_W)) u_cnt_i (
        .clk(clk), .rst_n(rst_n), .i_inc(w_inc_i), .i_clr(1'b0), .o_cnt(gnt_cnt_i)
    );
    arb_gnt_counter #(.CNT_W(CNT_W)) u_cnt_d (
        .clk(clk), .rst_n(rst_n), .i_inc(w_inc_d), .i_clr(1'b0), .o_cnt(gnt_cnt_d)
    );
endmodule

// File: tb/tb_l2_arbiter.sv
// tb_l2_arbiter: scoreboard bench for l2_arbiter with an L2 slave model and a narrow-counter twin.
module tb_l2_arbiter;
    typedef struct {
        logic         we;
        logic [11:0]  adr;
        logic [15:0]  sel;
        logic [127:0] dat;
        logic [127:0] rdat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic i_cyc, i_stb, i_we, i_ack, d_cyc, d_stb, d_we, d_ack;
    logic [11:0] i_adr, d_adr, l2_adr;
    logic [15:0] i_sel, d_sel, l2_sel, gnt_cnt_i, gnt_cnt_d;
    logic [127:0] i_dat_m, i_dat_s, d_dat_m, d_dat_s, l2_dat_m, l2_dat_s;
    logic l2_cyc, l2_stb, l2_we, l2_ack;

    logic s_i_ack, s_d_ack, s_l2_cyc, s_l2_stb, s_l2_we;
    logic [11:0] s_l2_adr;
    logic [15:0] s_l2_sel;
    logic [127:0] s_i_dat_s, s_d_dat_s, s_l2_dat_m;
    logic [1:0] s_cnt_i, s_cnt_d;

    l2_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .i_cyc(i_cyc), .i_stb(i_stb), .i_we(i_we), .i_adr(i_adr), .i_sel(i_sel),
        .i_dat_m(i_dat_m), .i_dat_s(i_dat_s), .i_ack(i_ack),
        .d_cyc(d_cyc), .d_stb(d_stb), .d_we(d_we), .d_adr(d_adr), .d_sel(d_sel),
        .d_dat_m(d_dat_m), .d_dat_s(d_dat_s), .d_ack(d_ack),
        .l2_cyc(l2_cyc), .l2_stb(l2_stb), .l2_we(l2_we), .l2_adr(l2_adr), .l2_sel(l2_sel),
        .l2_dat_m(l2_dat_m), .l2_dat_s(l2_dat_s), .l2_ack(l2_ack),
        .gnt_cnt_i(gnt_cnt_i), .gnt_cnt_d(gnt_cnt_d)
    );

    l2_arbiter #(.CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n),
        .i_cyc(i_cyc), .i_stb(i_stb), .i_we(i_we), .i_adr(i_adr), .i_sel(i_sel),
        .i_dat_m(i_dat_m), .i_dat_s(s_i_dat_s), .i_ack(s_i_ack),
        .d_cyc(d_cyc), .d_stb(d_stb), .d_we(d_we), .d_adr(d_adr), .d_sel(d_sel),
        .d_dat_m(d_dat_m), .d_dat_s(s_d_dat_s), .d_ack(s_d_ack),
        .l2_cyc(s_l2_cyc), .l2_stb(s_l2_stb), .l2_we(s_l2_we), .l2_adr(s_l2_adr), .l2_sel(s_l2_sel),
        .l2_dat_m(s_l2_dat_m), .l2_dat_s(l2_dat_s), .l2_ack(l2_ack),
        .gnt_cnt_i(s_cnt_i), .gnt_cnt_d(s_cnt_d)
    );

    int n_chk = 0;
    int n_pass = 0;
    int lat = 3;
    int wc = 0;
    exp_t q_i[$];
    exp_t q_d[$];
    logic q_ord[$];

    function automatic logic [127:0] slave_data(input logic [11:0] adr);
        return {32'hDEADBEEF, 84'h0, adr};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // L2 slave: acks a strobed request lat cycles after it appears
    initial begin
        l2_ack = 1'b0;
        l2_dat_s = '0;
        forever begin
            @(posedge clk);
            #2;
            l2_ack = 1'b0;
            if (l2_cyc && l2_stb) begin
                if (wc >= lat) begin
                    l2_ack = 1'b1;
                    l2_dat_s = slave_data(l2_adr);
                    wc = 0;
                end else wc++;
            end else wc = 0;
        end
    end

    // Monitor: every ack is checked against the expected grant order and the issuing port's queue
    always @(negedge clk) begin
        exp_t e;
        logic p;
        if (rst_n && (i_ack || d_ack)) begin
            p = d_ack;
            chk("ack_exclusive", {127'b0, i_ack & d_ack}, 128'd0);
            chk("order_pending", {127'b0, q_ord.size() > 0}, 128'd1);
            if (q_ord.size() > 0) chk("grant_order", {127'b0, p}, {127'b0, q_ord.pop_front()});
            chk("port_pending", {127'b0, (p ? q_d.size() : q_i.size()) > 0}, 128'd1);
            if ((p ? q_d.size() : q_i.size()) > 0) begin
                e = p ? q_d.pop_front() : q_i.pop_front();
                chk("l2_adr", {116'b0, l2_adr}, {116'b0, e.adr});
                chk("l2_we", {127'b0, l2_we}, {127'b0, e.we});
                chk("l2_sel", {112'b0, l2_sel}, {112'b0, e.sel});
                chk("l2_dat_m", l2_dat_m, e.dat);
                chk("dat_s", p ? d_dat_s : i_dat_s, e.rdat);
            end
        end
    end

    task automatic txn(input logic p, input logic [11:0] adr, input logic we,
                       input logic [15:0] sel, input logic [127:0] dat);
        exp_t e;
        logic got;
        e.we = we; e.adr = adr; e.sel = sel; e.dat = dat; e.rdat = slave_data(adr);
        got = 1'b0;
        if (p) begin
            q_d.push_back(e);
            d_cyc = 1; d_stb = 1; d_we = we; d_adr = adr; d_sel = sel; d_dat_m = dat;
        end else begin
            q_i.push_back(e);
            i_cyc = 1; i_stb = 1; i_we = we; i_adr = adr; i_sel = sel; i_dat_m = dat;
        end
        for (int k = 0; k < 60 && !got; k++) begin
            @(negedge clk);
            got = p ? d_ack : i_ack;
        end
        chk(p ? "ack_wait_d" : "ack_wait_i", {127'b0, got}, 128'd1);
        @(posedge clk);
        #1;
        if (p) begin d_cyc = 0; d_stb = 0; end
        else begin i_cyc = 0; i_stb = 0; end
    endtask

    task automatic do_reset();
        i_cyc = 0; i_stb = 0; d_cyc = 0; d_stb = 0;
        rst_n = 0;
        #1;
        chk("rst_l2_cyc", {127'b0, l2_cyc}, 128'd0);
        chk("rst_cnt_i", {112'b0, gnt_cnt_i}, 128'd0);
        chk("rst_cnt_d", {112'b0, gnt_cnt_d}, 128'd0);
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i_cyc = 0; i_stb = 0; i_we = 0; i_adr = '0; i_sel = '0; i_dat_m = '0;
        d_cyc = 0; d_stb = 0; d_we = 0; d_adr = '0; d_sel = '0; d_dat_m = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cyc", {127'b0, l2_cyc}, 128'd0);
        chk("rst_stb", {127'b0, l2_stb}, 128'd0);
        chk("rst_adr", {116'b0, l2_adr}, 128'd0);
        chk("rst_acks", {126'b0, i_ack, d_ack}, 128'd0);
        chk("rst_cnts", {96'b0, gnt_cnt_i, gnt_cnt_d}, 128'd0);
        rst_n = 1;

        // single I read with registered grant latency
        lat = 3;
        q_ord.push_back(0);
        fork
            txn(0, 12'h0A3, 0, 16'hFFFF, '0);
            begin
                #1;
                chk("t1_no_grant_yet", {127'b0, l2_cyc}, 128'd0);
                @(posedge clk);
                #1;
                chk("t1_cyc", {127'b0, l2_cyc}, 128'd1);
                chk("t1_adr", {116'b0, l2_adr}, 128'h0A3);
            end
        join
        chk("t1_cnt_i", {112'b0, gnt_cnt_i}, 128'd1);
        chk("t1_cnt_d", {112'b0, gnt_cnt_d}, 128'd0);

        // simultaneous requests after reset: I, D, then I again
        do_reset();
        lat = 1;
        q_ord.push_back(0); q_ord.push_back(1); q_ord.push_back(0); q_ord.push_back(1);
        fork
            txn(0, 12'h100, 0, 16'hFFFF, '0);
            txn(1, 12'h200, 0, 16'h000F, '0);
        join
        fork
            txn(0, 12'h101, 0, 16'hFFFF, '0);
            txn(1, 12'h201, 0, 16'h00F0, '0);
        join
        chk("t2_cnt_i", {112'b0, gnt_cnt_i}, 128'd2);
        chk("t2_cnt_d", {112'b0, gnt_cnt_d}, 128'd2);

        // continuous contention alternates strictly
        do_reset();
        lat = 2;
        for (int k = 0; k < 4; k++) begin q_ord.push_back(0); q_ord.push_back(1); end
        fork
            for (int k = 0; k < 4; k++) txn(0, 12'h300 + 12'(k), 0, 16'hFFFF, '0);
            for (int k = 0; k < 4; k++) txn(1, 12'h400 + 12'(k), 0, 16'hFF00, '0);
        join
        chk("t3_cnt_i", {112'b0, gnt_cnt_i}, 128'd4);
        chk("t3_cnt_d", {112'b0, gnt_cnt_d}, 128'd4);

        // D write while I idle
        lat = 1;
        q_ord.push_back(1);
        txn(1, 12'h155, 1, 16'h00F0, 128'h12345678_9ABCDEF0_0FEDCBA9_87654321);
        chk("t4_cnt_d", {112'b0, gnt_cnt_d}, 128'd5);
        chk("t4_cnt_i", {112'b0, gnt_cnt_i}, 128'd4);

        // abort of D, stray ack in IDLE, abort of I, then a tie still prefers I
        lat = 100;
        d_cyc = 1; d_stb = 1; d_we = 0; d_adr = 12'h2C0; d_sel = '1; d_dat_m = '0;
        @(posedge clk);
        #1;
        chk("t5_gnt_d", {127'b0, l2_cyc}, 128'd1);
        chk("t5_adr_d", {116'b0, l2_adr}, 128'h2C0);
        @(posedge clk);
        #1;
        d_cyc = 0; d_stb = 0;
        #1;
        chk("t5_abort_cyc", {127'b0, l2_cyc}, 128'd0);
        @(posedge clk);
        #1;
        chk("t5_cnt_d", {112'b0, gnt_cnt_d}, 128'd5);
        #2;
        l2_ack = 1;
        #1;
        chk("t5_stray_acks", {126'b0, i_ack, d_ack}, 128'd0);
        chk("t5_stray_cyc", {127'b0, l2_cyc}, 128'd0);
        l2_ack = 0;
        @(posedge clk);
        #1;
        i_cyc = 1; i_stb = 1; i_we = 0; i_adr = 12'h0C1; i_sel = '1;
        @(posedge clk);
        #1;
        chk("t5_gnt_i", {127'b0, l2_cyc}, 128'd1);
        i_cyc = 0; i_stb = 0;
        @(posedge clk);
        #1;
        chk("t5_cnt_i", {112'b0, gnt_cnt_i}, 128'd4);
        lat = 1;
        q_ord.push_back(0); q_ord.push_back(1);
        fork
            txn(0, 12'h0C2, 0, 16'hFFFF, '0);
            txn(1, 12'h2C2, 0, 16'hFFFF, '0);
        join

        // reset mid-grant, then saturation on the 2-bit twin
        do_reset();
        lat = 1;
        q_ord.push_back(0);
        txn(0, 12'h0F0, 0, 16'hFFFF, '0);
        chk("t6_cnt_before", {112'b0, gnt_cnt_i}, 128'd1);
        lat = 100;
        i_cyc = 1; i_stb = 1; i_adr = 12'h0F1;
        @(posedge clk);
        #1;
        chk("t6_gnt", {127'b0, l2_cyc}, 128'd1);
        #2;
        rst_n = 0;
        #1;
        chk("t6_rst_cyc", {127'b0, l2_cyc}, 128'd0);
        chk("t6_rst_cnt", {112'b0, gnt_cnt_i}, 128'd0);
        i_cyc = 0; i_stb = 0;
        @(posedge clk);
        #1;
        rst_n = 1;
        lat = 1;
        for (int k = 0; k < 4; k++) begin
            q_ord.push_back(0);
            txn(0, 12'h500 + 12'(k), 0, 16'hFFFF, '0);
            if (k == 1) chk("t6_sat_two", {126'b0, s_cnt_i}, 128'd2);
            if (k == 2) chk("t6_sat_full", {126'b0, s_cnt_i}, 128'd3);
        end
        chk("t6_sat_hold", {126'b0, s_cnt_i}, 128'd3);
        chk("t6_cnt_i", {112'b0, gnt_cnt_i}, 128'd4);

        @(posedge clk);
        #1;
        chk("queues_drained", 128'(q_i.size() + q_d.size() + q_ord.size()), 128'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
